msg_serializer: RTL and testbench

//  Drains wide coherence messages from the head of an upstream fifo (non-registered

---
 rtl/msg_serializer.sv | 97 +++++++++
 tb/tb_msg_serializer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/msg_serializer.sv
// Serializes wide messages from the head of an upstream fifo into narrow flits
// on a valid/ready link, one message in flight, back-to-back between messages.
module msg_serializer #(
    parameter int unsigned MSG_WIDTH  = 64,
    parameter int unsigned FLIT_WIDTH = 16,
    localparam int unsigned NUM_FLITS = (MSG_WIDTH + FLIT_WIDTH - 1) / FLIT_WIDTH,
    localparam int unsigned BEAT_W    = (NUM_FLITS > 1) ? $clog2(NUM_FLITS) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  fifo_empty_i,
    input  logic [MSG_WIDTH-1:0]  fifo_data_i,
    output logic                  fifo_pop_o,
    output logic                  flit_valid_o,
    input  logic                  flit_ready_i,
    output logic [FLIT_WIDTH-1:0] flit_data_o,
    output logic                  flit_last_o,
    output logic [BEAT_W-1:0]     flit_idx_o,
    output logic                  busy_o
);

    localparam int unsigned       BUF_W     = NUM_FLITS * FLIT_WIDTH;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUM_FLITS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic [BEAT_W-1:0]       beat_q, beat_d;
    logic [BUF_W-1:0]        msg_q, msg_d;

    logic                    sending;
    logic                    is_last;
    logic                    xfer;
    logic                    load;
    logic [FLIT_WIDTH-1:0]   flit_data;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            beat_q  <= '0;
            msg_q   <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            msg_q   <= msg_d;
        end
    end

    // Next-state and link-side outputs; flush outranks load and beat advance.
    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        msg_d     = msg_q;
        flit_data = '0;

        sending = (state_q == SEND);
        is_last = sending && (beat_q == LAST_BEAT);
        xfer    = sending && flit_ready_i;
        load    = !rst_i && !flush_i && !fifo_empty_i &&
                  ((state_q == IDLE) || (xfer && is_last));

        for (int unsigned i = 0; i < NUM_FLITS; i++) begin
            if (sending && (beat_q == BEAT_W'(i))) begin
                flit_data = msg_q[i*FLIT_WIDTH +: FLIT_WIDTH];
            end
        end

        if (flush_i) begin
            state_d = IDLE;
            beat_d  = '0;
        end else if (load) begin
            // Zero-extend so a partial final flit carries zeros above the message.
            msg_d                = '0;
            msg_d[MSG_WIDTH-1:0] = fifo_data_i;
            beat_d               = '0;
            state_d              = SEND;
        end else if (xfer) begin
            if (is_last) begin
                state_d = IDLE;
            end else begin
                beat_d = beat_q + BEAT_W'(1);
            end
        end
    end

    assign fifo_pop_o   = load;
    assign flit_valid_o = sending;
    assign flit_data_o  = flit_data;
    assign flit_last_o  = is_last;
    assign flit_idx_o   = sending ? beat_q : '0;
    assign busy_o       = sending;

endmodule

// File: tb/tb_msg_serializer.sv
// Bench for msg_serializer: directed scenarios plus randomized traffic scored
// against a queue-based model of the fifo and the expected flit stream.
module tb_msg_serializer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // 40-bit message, 16-bit flits -> 3 flits per message
    logic        flush_a, empty_a, pop_a, valid_a, ready_a, last_a, busy_a;
    logic [39:0] data_a;
    logic [15:0] fdata_a;
    logic [1:0]  idx_a;

    // 16-bit message, 16-bit flits -> 1 flit per message
    logic        flush_b, empty_b, pop_b, valid_b, ready_b, last_b, busy_b;
    logic [15:0] data_b;
    logic [15:0] fdata_b;
    logic [0:0]  idx_b;

    msg_serializer #(.MSG_WIDTH(40), .FLIT_WIDTH(16)) dut_a (
        .clk_i(clk), .rst_i(rst), .flush_i(flush_a),
        .fifo_empty_i(empty_a), .fifo_data_i(data_a), .fifo_pop_o(pop_a),
        .flit_valid_o(valid_a), .flit_ready_i(ready_a), .flit_data_o(fdata_a),
        .flit_last_o(last_a), .flit_idx_o(idx_a), .busy_o(busy_a)
    );

    msg_serializer #(.MSG_WIDTH(16), .FLIT_WIDTH(16)) dut_b (
        .clk_i(clk), .rst_i(rst), .flush_i(flush_b),
        .fifo_empty_i(empty_b), .fifo_data_i(data_b), .fifo_pop_o(pop_b),
        .flit_valid_o(valid_b), .flit_ready_i(ready_b), .flit_data_o(fdata_b),
        .flit_last_o(last_b), .flit_idx_o(idx_b), .busy_o(busy_b)
    );

    typedef struct {
        logic [15:0] d;
        logic [1:0]  idx;
        logic        last;
    } flit_t;

    int unsigned checks = 0;
    int unsigned errors = 0;

    logic [39:0] fq[$];
    flit_t       exp_q[$];
    logic [15:0] fqb[$];

    logic        s_pop, s_valid, s_last, s_busy;
    logic [15:0] s_data;
    logic [1:0]  s_idx;
    logic        hold_pend = 1'b0;
    logic [19:0] hold_snap = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected link traffic for one message: plain shifts of the message value.
    task automatic push_msg(input logic [39:0] m);
        flit_t f;
        for (int k = 0; k < 3; k++) begin
            f.d    = 16'(m >> (16 * k));
            f.idx  = 2'(k);
            f.last = (k == 2);
            exp_q.push_back(f);
        end
    endtask

    // One clock of DUT A: drive, sample at negedge, score, advance.
    task automatic cycle_a(input logic rdy, input logic fl);
        logic  exp_pop, exp_valid, did_pop;
        flit_t e;
        ready_a = rdy;
        flush_a = fl;
        empty_a = (fq.size() == 0);
        data_a  = (fq.size() == 0) ? 40'd0 : fq[0];
        @(negedge clk);
        s_pop   = pop_a;
        s_valid = valid_a;
        s_last  = last_a;
        s_busy  = busy_a;
        s_data  = fdata_a;
        s_idx   = idx_a;
        exp_valid = (exp_q.size() > 0);
        exp_pop   = !fl && (fq.size() > 0) &&
                    ((exp_q.size() == 0) || ((exp_q.size() == 1) && rdy));
        chk("valid", 64'(s_valid), 64'(exp_valid));
        chk("pop", 64'(s_pop), 64'(exp_pop));
        chk("busy", 64'(s_busy), 64'(exp_valid));
        if (hold_pend) chk("hold", 64'({s_valid, s_data, s_idx, s_last}), 64'(hold_snap));
        hold_pend = s_valid && !rdy && !fl;
        hold_snap = {s_valid, s_data, s_idx, s_last};
        if (s_valid && rdy && (exp_q.size() > 0)) begin
            e = exp_q.pop_front();
            chk("flit", 64'({s_data, s_idx, s_last}), 64'({e.d, e.idx, e.last}));
        end
        if (fl) exp_q.delete();
        did_pop = s_pop && (fq.size() > 0);
        if (did_pop) push_msg(fq[0]);
        @(posedge clk);
        #1;
        if (did_pop) void'(fq.pop_front());
    endtask

    initial begin
        int vcount;
        logic [15:0] mb[3];
        logic        exp_v, exp_p;

        rst = 1'b1;
        flush_a = 1'b0; ready_a = 1'b1; empty_a = 1'b0; data_a = 40'hFF_FFFF_FFFF;
        flush_b = 1'b0; ready_b = 1'b1; empty_b = 1'b1; data_b = 16'h0;
        #3;
        // Reset state, with a non-empty fifo so pop gating is visible
        chk("rst_init_outputs", 64'({pop_a, valid_a, fdata_a, last_a, idx_a, busy_a}), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single message, continuous ready
        fq.push_back(40'hAB_CDEF_0123);
        cycle_a(1'b1, 1'b0);
        chk("t1_pop", 64'({s_pop, s_valid}), 64'(2'b10));
        cycle_a(1'b1, 1'b0);
        chk("t1_f0", 64'({s_data, s_idx, s_last}), 64'({16'h0123, 2'd0, 1'b0}));
        cycle_a(1'b1, 1'b0);
        chk("t1_f1", 64'({s_data, s_idx, s_last}), 64'({16'hCDEF, 2'd1, 1'b0}));
        cycle_a(1'b1, 1'b0);
        chk("t1_f2", 64'({s_data, s_idx, s_last}), 64'({16'h00AB, 2'd2, 1'b1}));
        cycle_a(1'b1, 1'b0);
        chk("t1_idle", 64'(s_valid), 64'd0);

        // Two messages back-to-back
        fq.push_back(40'($urandom()) ^ (40'($urandom()) << 8));
        fq.push_back(40'($urandom()) ^ (40'($urandom()) << 8));
        cycle_a(1'b1, 1'b0);
        chk("t2_pop0", 64'(s_pop), 64'd1);
        vcount = 0;
        for (int k = 0; k < 6; k++) begin
            cycle_a(1'b1, 1'b0);
            vcount += int'(s_valid);
            if (k == 2) chk("t2_pop_on_last", 64'({s_pop, s_last}), 64'(2'b11));
        end
        chk("t2_valid_run", 64'(vcount), 64'd6);
        cycle_a(1'b1, 1'b0);
        chk("t2_idle", 64'(s_valid), 64'd0);

        // Backpressure at beat 1
        fq.push_back(40'hAB_CDEF_0123);
        fq.push_back(40'h0F_0E0D_0C0B);
        cycle_a(1'b1, 1'b0);
        cycle_a(1'b1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            cycle_a(1'b0, 1'b0);
            chk("t3_hold", 64'({s_valid, s_idx, s_data, s_pop}), 64'({1'b1, 2'd1, 16'hCDEF, 1'b0}));
        end
        cycle_a(1'b1, 1'b0);
        cycle_a(1'b1, 1'b0);
        chk("t3_resume", 64'({s_idx, s_data, s_pop}), 64'({2'd2, 16'h00AB, 1'b1}));
        for (int k = 0; k < 4; k++) cycle_a(1'b1, 1'b0);

        // Flush at beat 1 with the fifo non-empty
        fq.push_back(40'h11_2222_3333);
        fq.push_back(40'h44_5555_6666);
        cycle_a(1'b1, 1'b0);
        cycle_a(1'b1, 1'b0);
        cycle_a(1'b1, 1'b1);
        chk("t4_flush_cycle", 64'({s_pop, s_idx}), 64'({1'b0, 2'd1}));
        cycle_a(1'b1, 1'b0);
        chk("t4_after_flush", 64'({s_valid, s_pop}), 64'(2'b01));
        cycle_a(1'b1, 1'b0);
        chk("t4_restart", 64'({s_valid, s_idx, s_data}), 64'({1'b1, 2'd0, 16'h6666}));
        for (int k = 0; k < 4; k++) cycle_a(1'b1, 1'b0);

        // Randomized traffic, backpressure and occasional flush
        for (int k = 0; k < 400; k++) begin
            if (fq.size() < 4 && $urandom_range(0, 9) < 4)
                fq.push_back(40'($urandom()) ^ (40'($urandom()) << 8));
            cycle_a(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 49) == 0));
        end
        for (int k = 0; k < 20; k++) cycle_a(1'b1, 1'b0);
        chk("drain_empty", 64'(exp_q.size() + fq.size()), 64'd0);

        // Asynchronous reset mid-message
        fq.push_back(40'h12_3456_789A);
        fq.push_back(40'h9A_BCDE_F012);
        cycle_a(1'b1, 1'b0);
        cycle_a(1'b1, 1'b0);
        cycle_a(1'b0, 1'b0);
        empty_a = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("t5_rst_async", 64'({pop_a, valid_a, fdata_a, last_a, idx_a, busy_a}), 64'd0);
        fq.delete();
        exp_q.delete();
        hold_pend = 1'b0;
        empty_a = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cycle_a(1'b1, 1'b0);
            chk("t5_idle", 64'({s_valid, s_pop}), 64'd0);
        end

        // Single-flit messages on the 16/16 instance
        for (int k = 0; k < 3; k++) begin
            mb[k] = 16'($urandom());
            fqb.push_back(mb[k]);
        end
        for (int c = 0; c < 5; c++) begin
            empty_b = (fqb.size() == 0);
            data_b  = (fqb.size() == 0) ? 16'd0 : fqb[0];
            @(negedge clk);
            exp_v = (c >= 1) && (c <= 3);
            exp_p = (c <= 2);
            chk("t6_valid", 64'(valid_b), 64'(exp_v));
            chk("t6_pop", 64'(pop_b), 64'(exp_p));
            if (exp_v)
                chk("t6_flit", 64'({fdata_b, idx_b, last_b}), 64'({mb[c-1], 1'b0, 1'b1}));
            @(posedge clk);
            #1;
            if (exp_p && fqb.size() > 0) void'(fqb.pop_front());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
